vault_regfile: RTL and testbench

Parametrised register file succeeding the 4x8 BitVault: DEPTH entries of DATA_W bits, one write port and two independent registered read ports with write-first bypass. A built-in clear sequencer zeroes every entry after reset or on request, so no entry is ever read uninitialised. The block sits beside the datapath as the general-purpose storage used by downstream control logic.

---
 rtl/vault_pkg.sv | 27 ++
 rtl/vault_regfile_if.sv | 56 +++++
 rtl/vault_clear_fsm.sv | 83 ++++++++
 rtl/vault_regfile.sv | 124 ++++++++++++
 tb/tb_vault_regfile.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vault_pkg.sv
// ============================================================================
// Module      : vault_pkg
// Description : Shared types, default sizes and parity helper for vault_regfile
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vault_pkg;

    typedef enum logic [0:0] {
        VAULT_CLEAR = 1'b0,
        VAULT_IDLE  = 1'b1
    } vault_state_e;

    localparam int VAULT_DATA_W    = 8;
    localparam int VAULT_DEPTH     = 16;
    // Widest entry the parity helper accepts; narrower data is zero-extended.
    localparam int VAULT_PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic vault_parity(input logic [VAULT_PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vault_regfile_if.sv
// ============================================================================
// Module      : vault_regfile_if
// Description : Write/read/clear bus of vault_regfile; master drives requests.
//               Parity error outputs exist only when VAULT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vault_regfile_if
    import vault_pkg::*;
#(
    parameter int DATA_W = VAULT_DATA_W,
    parameter int DEPTH  = VAULT_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_a;
    logic              rd_valid_b;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
`ifdef VAULT_PARITY_EN
    logic              rd_perr_a;
    logic              rd_perr_b;
`endif

    modport master (
`ifdef VAULT_PARITY_EN
        input  rd_perr_a, rd_perr_b,
`endif
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clr_req,
        input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, clr_done
    );

    modport slave (
`ifdef VAULT_PARITY_EN
        output rd_perr_a, rd_perr_b,
`endif
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clr_req,
        output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, clr_done
    );

endinterface

`default_nettype wire

// File: rtl/vault_clear_fsm.sv
// ============================================================================
// Module      : vault_clear_fsm
// Description : Clear sequencer: walks every entry writing zero after reset or
//               on request, and gates normal accesses while it runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vault_clear_fsm
    import vault_pkg::*;
#(
    parameter int DEPTH  = VAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_accept
);

    vault_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            VAULT_CLEAR: begin
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = VAULT_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            VAULT_IDLE: begin
                if (i_clr_req) begin
                    state_d = VAULT_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = VAULT_CLEAR;
                idx_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VAULT_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_clr_done = done_q;
    assign o_clr_we   = (state_q == VAULT_CLEAR);
    assign o_clr_addr = idx_q;
    assign o_accept   = (state_q == VAULT_IDLE);

endmodule

`default_nettype wire

// File: rtl/vault_regfile.sv
// ============================================================================
// Module      : vault_regfile
// Description : DEPTH x DATA_W register file, one write port, two registered
//               write-first read ports, self-clearing. Define VAULT_PARITY_EN
//               to store an even-parity bit per entry and flag read errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vault_regfile
    import vault_pkg::*;
#(
    parameter int DATA_W = VAULT_DATA_W,
    parameter int DEPTH  = VAULT_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    vault_regfile_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
`ifdef VAULT_PARITY_EN
    localparam int c_store_w = DATA_W + 1;
`else
    localparam int c_store_w = DATA_W;
`endif

    logic                 w_accept;
    logic                 w_clr_we;
    logic [ADDR_W-1:0]    w_clr_addr;
    logic [c_store_w-1:0] w_wr_word;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_mem_waddr;
    logic [c_store_w-1:0] w_mem_wdata;
    logic [1:0]           w_rd_en;
    logic [ADDR_W-1:0]    w_rd_addr [2];

    // Deliberately unreset: the clear sequence owns initialisation.
    logic [c_store_w-1:0] mem_q [DEPTH];

    vault_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (bus.clr_req),
        .o_busy     (bus.busy),
        .o_clr_done (bus.clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_accept   (w_accept)
    );

`ifdef VAULT_PARITY_EN
    assign w_wr_word = {vault_parity(VAULT_PAR_MAX_W'(bus.wr_data)), bus.wr_data};
`else
    assign w_wr_word = bus.wr_data;
`endif

    // Clear writes (data 0, parity 0) and user writes never coincide.
    assign w_mem_we    = w_clr_we || (w_accept && bus.wr_en);
    assign w_mem_waddr = w_clr_we ? w_clr_addr : bus.wr_addr;
    assign w_mem_wdata = w_clr_we ? '0 : w_wr_word;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign w_rd_en      = {bus.rd_en_b, bus.rd_en_a};
    assign w_rd_addr[0] = bus.rd_addr_a;
    assign w_rd_addr[1] = bus.rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic                 w_hit;
        logic [c_store_w-1:0] w_word;
        logic                 valid_d, valid_q;
        logic [DATA_W-1:0]    data_d, data_q;
`ifdef VAULT_PARITY_EN
        logic                 perr_d, perr_q;
`endif

        always_comb begin
            w_hit   = bus.wr_en && (bus.wr_addr == w_rd_addr[p]);
            w_word  = w_hit ? w_wr_word : mem_q[w_rd_addr[p]];
            valid_d = w_accept && w_rd_en[p];
            data_d  = valid_d ? w_word[DATA_W-1:0] : data_q;
`ifdef VAULT_PARITY_EN
            perr_d  = valid_d &&
                      (vault_parity(VAULT_PAR_MAX_W'(w_word[DATA_W-1:0])) != w_word[DATA_W]);
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
`ifdef VAULT_PARITY_EN
                perr_q  <= 1'b0;
`endif
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
`ifdef VAULT_PARITY_EN
                perr_q  <= perr_d;
`endif
            end
        end
    end

    assign bus.rd_data_a  = g_rd_port[0].data_q;
    assign bus.rd_data_b  = g_rd_port[1].data_q;
    assign bus.rd_valid_a = g_rd_port[0].valid_q;
    assign bus.rd_valid_b = g_rd_port[1].valid_q;
`ifdef VAULT_PARITY_EN
    assign bus.rd_perr_a  = g_rd_port[0].perr_q;
    assign bus.rd_perr_b  = g_rd_port[1].perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vault_regfile.sv
// ============================================================================
// Module      : tb_vault_regfile
// Description : Scoreboard bench for vault_regfile; parity scenario is built
//               only when VAULT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vault_regfile;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vault_regfile_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    vault_regfile #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Each entry is {expected data, expected parity error}.
    logic [DW:0] q_a [$];
    logic [DW:0] q_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus driven at a falling edge; expected read data is
    // queued only when the request should be accepted.
    task automatic issue(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic rea, input logic [3:0] ra,
                         input logic reb, input logic [3:0] rb,
                         input logic creq, input logic acc,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic pea = 1'b0);
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_en_a   = rea;
        bus.rd_addr_a = ra;
        bus.rd_en_b   = reb;
        bus.rd_addr_b = rb;
        bus.clr_req   = creq;
        if (acc && rea) q_a.push_back({ea, pea});
        if (acc && reb) q_b.push_back({eb, 1'b0});
        @(negedge clk);
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Called just after rst_n rises: 16 busy cycles, then the done pulse.
    task automatic wait_clear();
        #1;
        check("clr_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("clr_busy", 32'(bus.busy), 32'd1);
            check("clr_done_early", 32'(bus.clr_done), 32'd0);
        end
        @(negedge clk);
        check("clr_end_busy", 32'(bus.busy), 32'd0);
        check("clr_done_pulse", 32'(bus.clr_done), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        logic [DW:0] e;
        if (bus.rd_valid_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_a_unexpected: valid with data %0h, none expected", bus.rd_data_a);
            end else begin
                e = q_a.pop_front();
                check("rd_data_a", 32'(bus.rd_data_a), 32'(e[DW:1]));
`ifdef VAULT_PARITY_EN
                check("rd_perr_a", 32'(bus.rd_perr_a), 32'(e[0]));
`endif
            end
        end
        if (bus.rd_valid_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_b_unexpected: valid with data %0h, none expected", bus.rd_data_b);
            end else begin
                e = q_b.pop_front();
                check("rd_data_b", 32'(bus.rd_data_b), 32'(e[DW:1]));
`ifdef VAULT_PARITY_EN
                check("rd_perr_b", 32'(bus.rd_perr_b), 32'(e[0]));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
        bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;
        bus.clr_req = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check("rst_valid_a", 32'(bus.rd_valid_a), 32'd0);
        check("rst_valid_b", 32'(bus.rd_valid_b), 32'd0);
        check("rst_data_a", 32'(bus.rd_data_a), 32'd0);
        check("rst_data_b", 32'(bus.rd_data_b), 32'd0);
        #2 rst_n = 1'b1;
        wait_clear();

        // Every entry reads zero after the power-up clear
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b1, 4'(DEPTH - 1 - i), 1'b0, 1'b1, 8'h00, 8'h00);
            if (i == 0) check("clr_done_one_cycle", 32'(bus.clr_done), 32'd0);
        end
        idle();

        // Write then read on both ports
        issue(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 4'd4, 1'b0, 1'b1, 8'hA5, 8'h00);
        idle();

        // Write-first bypass on both ports, then a plain read of the same entry
        issue(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b1, 8'h3C, 8'h3C);
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b1, 8'h3C, 8'h3C);
        idle();

        // Fill with 0xFF, request clear with a same-cycle write and read
        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, 4'(i), 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue(1'b1, 4'd0, 8'h11, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 8'h00);
        check("clr_req_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            issue(1'b1, 4'(k - 1), 8'h77, 1'b1, 4'(k), 1'b1, 4'(k), 1'(k % 2), 1'b0, 8'h00, 8'h00);
            check("busy_window", 32'(bus.busy), (k < DEPTH) ? 32'd1 : 32'd0);
            check("busy_clr_done", 32'(bus.clr_done), (k < DEPTH) ? 32'd0 : 32'd1);
            check("busy_valid_a", 32'(bus.rd_valid_a), 32'd0);
            check("busy_valid_b", 32'(bus.rd_valid_b), 32'd0);
            check("busy_hold_a", 32'(bus.rd_data_a), 32'hFF);
        end
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b1, 4'(i), 1'b0, 1'b1, 8'h00, 8'h00);
        idle();

        // Asynchronous reset while read data is valid
        issue(1'b1, 4'd9, 8'h5A, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b1, 8'h5A, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid_a", 32'(bus.rd_valid_a), 32'd0);
        check("arst_data_a", 32'(bus.rd_data_a), 32'd0);
        check("arst_data_b", 32'(bus.rd_data_b), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd1);
        idle();
        idle();

        // Reset again at clear index 8, then a full clear must rerun
        #2 rst_n = 1'b1;
        #1 check("rel_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_clr_busy", 32'(bus.busy), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_arst_busy", 32'(bus.busy), 32'd1);
        check("mid_arst_done", 32'(bus.clr_done), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_clear();
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b1, 4'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        idle();

`ifdef VAULT_PARITY_EN
        // Corrupt the stored parity of entry 2 through the backdoor
        issue(1'b1, 4'd2, 8'h33, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue(1'b1, 4'd6, 8'h07, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        idle();
        dut.mem_q[2][DW] = ~dut.mem_q[2][DW];
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd6, 1'b0, 1'b1, 8'h33, 8'h07, 1'b1);
        issue(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b1, 8'h07, 8'h00, 1'b0);
        issue(1'b1, 4'd2, 8'h01, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        idle();
`endif

        idle();
        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
